cdc_play_sequencer: RTL
=======================

# cdc_play_sequencer

Play-path sequencer for the mclk side of the audio CDC path, clocked by `rsync_clk`. It holds the mclk-domain logic in reset for a programmed number of cycles after `rst_n` release, and gates playback so that `play_out` rises only on a delivered sample. It closes playback only on a frame boundary. It also watches the sample-tick stream for underruns and counts played samples.

## Interface
Parameters:
- RESET_HOLD, 8, cycles `mrst_n_out` stays low after `rst_n` release (≥2)
- TICK_TIMEOUT, 256, idle cycles without `tick_in` in PLAY that flag an underrun
- DRAIN_MAX, 1024, maximum cycles spent in DRAIN waiting for `frame_in`

Ports:
- rsync_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- test_mode_in  in  1  1: reset hold shortened to 1 cycle
- play_in  in  1  play request level, already synchronous to `rsync_clk`
- tick_in  in  1  1-cycle pulse: new sample pair delivered
- frame_in  in  1  1-cycle pulse: serializer frame boundary
- clr_in  in  1  clears `underrun_out`
- mrst_n_out  out  1  sequenced local reset, active-low
- ready_out  out  1  sequencer idle and able to accept play
- play_out  out  1  gated play enable to the serializer
- underrun_out  out  1  sticky underrun flag
- sample_cnt_out  out  16  samples played since last start, saturating
- state_out  out  3  current state encoding, for debug

## Operation
- All outputs are registered. Reset values: state RST_HOLD, `mrst_n_out`=0, `ready_out`=0, `play_out`=0, `underrun_out`=0, `sample_cnt_out`=0, all counters 0.
- RST_HOLD: hold counter increments each cycle.
  - At count RESET_HOLD-1, or immediately when `test_mode_in`=1, go to IDLE.
  - `mrst_n_out`=1 from the IDLE entry onward.
- IDLE:
  - `ready_out`=1.
  - `play_in`=1 → ARM; `sample_cnt` clears on ARM entry.
- ARM: waits for the first sample.
  - `play_in`=0 → IDLE. This has priority over a simultaneous `tick_in`.
  - `tick_in`=1 → PLAY, and this tick is counted.
- PLAY: `play_out`=1.
  - Watchdog clears on `tick_in` and increments otherwise.
  - Watchdog reaching TICK_TIMEOUT sets `underrun_out` and clears the watchdog. State stays PLAY.
  - `play_in`=0 → DRAIN.
- DRAIN: `play_out` stays 1 and the drain counter increments.
  - `play_in`=1 → PLAY (no gap). Priority order: `play_in`, then `frame_in`, then timeout.
  - `frame_in`=1 → IDLE.
  - Drain count reaching DRAIN_MAX-1 → IDLE.
- `sample_cnt_out` increments on each `tick_in` accepted in ARM→PLAY, PLAY, or DRAIN. It saturates at 16'hFFFF.
- `underrun_out` clears on `clr_in`. A simultaneous set and clear leaves it set.
- `ready_out`=1 only in IDLE. `play_out`=1 only in PLAY and DRAIN.
- `state_out` encoding: RST_HOLD=0, IDLE=1, ARM=2, PLAY=3, DRAIN=4.

## Timing
- Reset release: `mrst_n_out` and `ready_out` rise on the RESET_HOLD-th `rsync_clk` edge after `rst_n` deasserts. With `test_mode_in`=1, they rise on the 1st edge.
- Play start:
  - `play_in` high at edge n → `ready_out` low after edge n+1.
  - `tick_in` at edge m in ARM → `play_out` high after edge m+1.
- Stop: `frame_in` at edge k in DRAIN → `play_out` low and `ready_out` high after edge k+1.
- Underrun: `underrun_out` rises TICK_TIMEOUT cycles after the last tick.
- `rst_n` assertion mid-operation: all outputs immediately return to reset values, asynchronously, including `mrst_n_out`=0. The full hold sequence repeats on release.

## Structure
- Shared package: the state enum `play_seq_state_t` (3-bit) and a constant `SAMPLE_CNT_W` = 16.
- One sub-module, `sat_counter`: a parameterized-width up-counter with clear, enable, terminal-count flag and optional saturation. It is reused for the hold, watchdog, drain and sample counters.

## Test plan
- Reset sequencing: release `rst_n` with RESET_HOLD=8 and `test_mode_in`=0 → `mrst_n_out` and `ready_out` go 0→1 exactly 8 edges later. With `test_mode_in`=1 → they rise after 1 edge.
- Play start: raise `play_in`, then 5 cycles later pulse `tick_in` → `play_out` rises 1 cycle after the tick, `sample_cnt_out`=1, `state_out`=3.
- Stop on frame: in PLAY, drop `play_in`, then pulse `frame_in` 20 cycles later → `play_out` stays 1 for those 20 cycles and falls 1 cycle after `frame_in`. Repeat with no `frame_in` → the DRAIN_MAX timeout returns the block to IDLE.
- Underrun: in PLAY, withhold `tick_in` for 256 cycles → `underrun_out`=1 and stays 1. Pulse `clr_in` and an underrun event in the same cycle → flag stays 1. Pulse `clr_in` alone → flag 0.
- Boundary events:
  - `play_in` falls in the same cycle as `tick_in` in ARM → IDLE, `play_out` stays 0.
  - `play_in` returns in DRAIN → PLAY with no `play_out` gap.
  - 65540 ticks → `sample_cnt_out`=16'hFFFF.
- Mid-operation reset: assert `rst_n` low during PLAY → all outputs are at reset values before the next edge, and the hold sequence repeats on release.

Source files
------------

// File: rtl/cdc_play_sequencer_pkg.sv
// cdc_play_sequencer_pkg
// Shared types and constants for the mclk-side play-path sequencer.
//   play_seq_state_t : sequencer state encoding (also exported on state_out)
//   SAMPLE_CNT_W     : width of the played-sample counter
package cdc_play_sequencer_pkg;

    localparam int unsigned SAMPLE_CNT_W = 16;

    typedef enum logic [2:0] {
        StRstHold = 3'd0,
        StIdle    = 3'd1,
        StArm     = 3'd2,
        StPlay    = 3'd3,
        StDrain   = 3'd4
    } play_seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter with synchronous clear, enable, terminal-count flag and optional
// saturation at the terminal count.
// Ports:
//   clk_in   : clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   clr_in   : synchronous clear, has priority over enable
//   en_in    : count enable
//   cnt_out  : current count (registered)
//   tc_out   : count equals TermCount
module sat_counter #(
    parameter int unsigned Width     = 8,
    parameter int unsigned TermCount = 255,
    parameter bit          Saturate  = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clr_in,
    input  logic             en_in,
    output logic [Width-1:0] cnt_out,
    output logic             tc_out
);

    logic [Width-1:0] cnt_d, cnt_q;
    logic             tc;

    assign tc = (cnt_q == Width'(TermCount));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (en_in && !(Saturate && tc)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc_out  = tc;

endmodule

// File: rtl/cdc_play_sequencer.sv
// cdc_play_sequencer
// Play-path sequencer for the mclk side of the audio CDC path. Holds the mclk
// domain in reset after rst_n release, starts playback only on a delivered
// sample, stops only on a frame boundary (or drain timeout), flags tick
// underruns and counts played samples.
// Ports:
//   rsync_clk      : clock
//   rst_n          : asynchronous active-low reset
//   test_mode_in   : shortens the reset hold to one cycle
//   play_in        : play request level (synchronous)
//   tick_in        : pulse, new sample pair delivered
//   frame_in       : pulse, serializer frame boundary
//   clr_in         : clears underrun_out
//   mrst_n_out     : sequenced local reset, active-low
//   ready_out      : idle and able to accept play
//   play_out       : gated play enable
//   underrun_out   : sticky underrun flag
//   sample_cnt_out : saturating count of samples played since last start
//   state_out      : current state, for debug
module cdc_play_sequencer
    import cdc_play_sequencer_pkg::*;
#(
    parameter int unsigned RESET_HOLD   = 8,
    parameter int unsigned TICK_TIMEOUT = 256,
    parameter int unsigned DRAIN_MAX    = 1024
) (
    input  logic                    rsync_clk,
    input  logic                    rst_n,
    input  logic                    test_mode_in,
    input  logic                    play_in,
    input  logic                    tick_in,
    input  logic                    frame_in,
    input  logic                    clr_in,
    output logic                    mrst_n_out,
    output logic                    ready_out,
    output logic                    play_out,
    output logic                    underrun_out,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt_out,
    output logic [2:0]              state_out
);

    localparam int unsigned HoldW  = $clog2(RESET_HOLD);
    localparam int unsigned WdW    = $clog2(TICK_TIMEOUT);
    localparam int unsigned DrainW = $clog2(DRAIN_MAX);

    play_seq_state_t state_d, state_q;
    logic mrst_n_d, mrst_n_q;
    logic ready_d, ready_q;
    logic play_d, play_q;
    logic underrun_d, underrun_q;

    logic              hold_tc, wd_tc, drain_tc, sample_tc;
    logic [HoldW-1:0]  hold_cnt;
    logic [WdW-1:0]    wd_cnt;
    logic [DrainW-1:0] drain_cnt;

    logic underrun_set;
    logic sample_clr, sample_en;

    // Reset hold: counts only while holding; terminal count releases to IDLE.
    sat_counter #(
        .Width     (HoldW),
        .TermCount (RESET_HOLD - 1),
        .Saturate  (1'b1)
    ) u_hold_cnt (
        .clk_in  (rsync_clk),
        .rst_n   (rst_n),
        .clr_in  (1'b0),
        .en_in   (state_q == StRstHold),
        .cnt_out (hold_cnt),
        .tc_out  (hold_tc)
    );

    // Tick watchdog: cleared outside PLAY, on every tick, and when it fires.
    sat_counter #(
        .Width     (WdW),
        .TermCount (TICK_TIMEOUT - 1),
        .Saturate  (1'b0)
    ) u_wd_cnt (
        .clk_in  (rsync_clk),
        .rst_n   (rst_n),
        .clr_in  ((state_q != StPlay) || tick_in || wd_tc),
        .en_in   (1'b1),
        .cnt_out (wd_cnt),
        .tc_out  (wd_tc)
    );

    // Drain timer: restarts on every DRAIN entry.
    sat_counter #(
        .Width     (DrainW),
        .TermCount (DRAIN_MAX - 1),
        .Saturate  (1'b0)
    ) u_drain_cnt (
        .clk_in  (rsync_clk),
        .rst_n   (rst_n),
        .clr_in  (state_q != StDrain),
        .en_in   (1'b1),
        .cnt_out (drain_cnt),
        .tc_out  (drain_tc)
    );

    // A tick in ARM counts only if play_in is still held (ARM->PLAY taken).
    assign sample_clr = (state_q == StIdle) && play_in;
    assign sample_en  = tick_in && !sample_tc &&
                        (((state_q == StArm) && play_in) ||
                         (state_q == StPlay) || (state_q == StDrain));

    sat_counter #(
        .Width     (SAMPLE_CNT_W),
        .TermCount ((2 ** SAMPLE_CNT_W) - 1),
        .Saturate  (1'b1)
    ) u_sample_cnt (
        .clk_in  (rsync_clk),
        .rst_n   (rst_n),
        .clr_in  (sample_clr),
        .en_in   (sample_en),
        .cnt_out (sample_cnt_out),
        .tc_out  (sample_tc)
    );

    assign underrun_set = (state_q == StPlay) && !tick_in && wd_tc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRstHold: if (test_mode_in || hold_tc) state_d = StIdle;
            StIdle:    if (play_in) state_d = StArm;
            StArm: begin
                if (!play_in)     state_d = StIdle;
                else if (tick_in) state_d = StPlay;
            end
            StPlay:    if (!play_in) state_d = StDrain;
            StDrain: begin
                if (play_in)       state_d = StPlay;
                else if (frame_in) state_d = StIdle;
                else if (drain_tc) state_d = StIdle;
            end
            default:   state_d = StRstHold;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        mrst_n_d   = (state_d != StRstHold);
        ready_d    = (state_d == StIdle);
        play_d     = (state_d == StPlay) || (state_d == StDrain);
        // Set wins over a simultaneous clear.
        underrun_d = underrun_set || (underrun_q && !clr_in);
    end

    always_ff @(posedge rsync_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRstHold;
            mrst_n_q   <= 1'b0;
            ready_q    <= 1'b0;
            play_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mrst_n_q   <= mrst_n_d;
            ready_q    <= ready_d;
            play_q     <= play_d;
            underrun_q <= underrun_d;
        end
    end

    assign mrst_n_out   = mrst_n_q;
    assign ready_out    = ready_q;
    assign play_out     = play_q;
    assign underrun_out = underrun_q;
    assign state_out    = state_q;

endmodule
